// File: rtl/asi_w_mem.sv
// AXI4 slave write-path responder: one AW burst at a time, per-beat FIXED/INCR/WRAP
// address generation, byte-enabled single-port memory write, single B response.
module asi_w_mem #(
    parameter int unsigned AXI_DW     = 128,
    parameter int unsigned AXI_AW     = 32,
    parameter int unsigned AXI_IW     = 8,
    parameter int unsigned AXI_LW     = 8,
    parameter int unsigned AXI_SW     = 3,
    parameter int unsigned AXI_BURSTW = 2,
    parameter int unsigned AXI_BRESPW = 2,
    parameter int unsigned MEM_BYTES  = 65536,
    parameter int unsigned AXI_BYTES  = AXI_DW / 8,
    parameter int unsigned AXI_WSTRBW = AXI_BYTES
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [AXI_IW-1:0]     AWID,
    input  logic [AXI_AW-1:0]     AWADDR,
    input  logic [AXI_LW-1:0]     AWLEN,
    input  logic [AXI_SW-1:0]     AWSIZE,
    input  logic [AXI_BURSTW-1:0] AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [AXI_DW-1:0]     WDATA,
    input  logic [AXI_WSTRBW-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [AXI_IW-1:0]     BID,
    output logic [AXI_BRESPW-1:0] BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  mem_we,
    output logic [AXI_AW-1:0]     mem_addr,
    output logic [AXI_DW-1:0]     mem_wdata,
    output logic [AXI_WSTRBW-1:0] mem_be
);
    localparam int unsigned MAX_SIZE = $clog2(AXI_BYTES);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state;
    logic [AXI_IW-1:0]       id_q;
    logic [AXI_AW-1:0]       addr_q;
    logic [AXI_LW-1:0]       len_q;
    logic [AXI_SW-1:0]       size_q;
    logic [AXI_BURSTW-1:0]   burst_q;
    logic [AXI_LW-1:0]       cnt_q;
    logic                    slv_q;
    logic                    dec_q;
    logic                    sup_q;
    logic                    first_q;

    logic [31:0]             addr32, nbytes, size_mask, lane_addr, lo;
    logic [31:0]             bnd_mask, incr_next, wrap_next, next_addr;
    logic [31:0]             aw_nbytes;
    logic [AXI_WSTRBW-1:0]   lane;
    logic                    oor, beat_last, wlast_bad, wrap_len_ok, aw_bad;

    always_comb begin
        addr32    = 32'(addr_q);
        nbytes    = 32'd1 << size_q;
        size_mask = nbytes - 32'd1;
        // only the first beat may be unaligned; later beats use the size-aligned address
        lane_addr = first_q ? addr32 : (addr32 & ~size_mask);
        lo        = lane_addr & 32'(AXI_BYTES - 1);
        lane      = '0;
        for (int unsigned i = 0; i < AXI_WSTRBW; i++) begin
            lane[i] = (i >= lo) && (i < lo + nbytes);
        end
        bnd_mask  = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
        incr_next = (addr32 & ~size_mask) + nbytes;
        wrap_next = (addr32 & ~bnd_mask) + ((addr32 + nbytes) & bnd_mask);
        case (burst_q)
            AXI_BURSTW'(1): next_addr = incr_next;
            AXI_BURSTW'(2): next_addr = wrap_next;
            default:        next_addr = addr32;
        endcase
        oor       = addr32 >= MEM_BYTES;
        beat_last = cnt_q == len_q;
        wlast_bad = WLAST != beat_last;

        aw_nbytes   = 32'd1 << AWSIZE;
        wrap_len_ok = (32'(AWLEN) == 32'd1) || (32'(AWLEN) == 32'd3) ||
                      (32'(AWLEN) == 32'd7) || (32'(AWLEN) == 32'd15);
        aw_bad      = (32'(AWSIZE) > MAX_SIZE) || (AWBURST == AXI_BURSTW'(3)) ||
                      ((AWBURST == AXI_BURSTW'(2)) &&
                       (!wrap_len_ok || ((32'(AWADDR) & (aw_nbytes - 32'd1)) != 32'd0)));
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BID       <= '0;
            BRESP     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            slv_q     <= 1'b0;
            dec_q     <= 1'b0;
            sup_q     <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        id_q    <= AWID;
                        addr_q  <= AWADDR;
                        len_q   <= AWLEN;
                        size_q  <= AWSIZE;
                        burst_q <= AWBURST;
                        cnt_q   <= '0;
                        slv_q   <= aw_bad;
                        sup_q   <= aw_bad;
                        dec_q   <= 1'b0;
                        first_q <= 1'b1;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (WVALID && WREADY) begin
                        if (!sup_q && !oor) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= AXI_AW'(addr32 & ~32'(AXI_BYTES - 1));
                            mem_wdata <= WDATA;
                            mem_be    <= WSTRB & lane;
                        end
                        dec_q   <= dec_q | oor;
                        slv_q   <= slv_q | wlast_bad;
                        addr_q  <= AXI_AW'(next_addr);
                        cnt_q   <= cnt_q + AXI_LW'(1);
                        first_q <= 1'b0;
                        if (beat_last) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BID    <= id_q;
                            BRESP  <= (slv_q || wlast_bad) ? AXI_BRESPW'(2) :
                                      (dec_q || oor)       ? AXI_BRESPW'(3) : '0;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_asi_w_mem.sv
// Self-checking bench for asi_w_mem: directed bursts plus randomized bursts
// checked against a burst-level reference model of addresses, lanes and responses.
module tb_asi_w_mem;
    localparam int unsigned DW   = 128;
    localparam int unsigned AW   = 32;
    localparam int unsigned IW   = 8;
    localparam int unsigned NB   = DW / 8;
    localparam int unsigned MEMB = 65536;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [IW-1:0]   AWID = '0;
    logic [AW-1:0]   AWADDR = '0;
    logic [7:0]      AWLEN = '0;
    logic [2:0]      AWSIZE = '0;
    logic [1:0]      AWBURST = '0;
    logic            AWVALID = 1'b0;
    logic            AWREADY;
    logic [DW-1:0]   WDATA = '0;
    logic [NB-1:0]   WSTRB = '0;
    logic            WLAST = 1'b0;
    logic            WVALID = 1'b0;
    logic            WREADY;
    logic [IW-1:0]   BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY = 1'b1;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [NB-1:0]   mem_be;

    asi_w_mem #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .MEM_BYTES(MEMB)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc++;

    logic [31:0]   got_addr[$];
    logic [DW-1:0] got_data[$];
    logic [NB-1:0] got_be[$];
    int            got_cyc[$];
    always @(negedge ACLK) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            got_be.push_back(mem_be);
            got_cyc.push_back(cyc);
        end
    end

    logic [31:0]   exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [NB-1:0] exp_be[$];
    logic [DW-1:0] data_a[0:15];
    logic [NB-1:0] strb_a[0:15];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: walks the burst beat by beat with plain arithmetic.
    task automatic model(input longint unsigned addr, input int len, input int size,
                         input int burst, input int wl_beat, output int resp);
        longint unsigned a = addr;
        longint unsigned nb = longint'(1) << size;
        longint unsigned la, lo, bnd;
        logic [NB-1:0] be;
        bit bad, wl, dec;
        bad = (size > 4) || (burst == 3) ||
              (burst == 2 && (!(len == 1 || len == 3 || len == 7 || len == 15) || (a % nb) != 0));
        wl = 0;
        dec = 0;
        exp_addr.delete(); exp_data.delete(); exp_be.delete();
        for (int b = 0; b <= len; b++) begin
            la = (b == 0) ? a : a - (a % nb);
            lo = la % NB;
            be = '0;
            for (int i = 0; i < int'(NB); i++)
                if (i >= lo && i < lo + nb) be[i] = 1'b1;
            be &= strb_a[b];
            if (a >= MEMB) dec = 1;
            else if (!bad) begin
                exp_addr.push_back(32'(a - (a % NB)));
                exp_data.push_back(data_a[b]);
                exp_be.push_back(be);
            end
            if ((b == wl_beat) != (b == len)) wl = 1;
            if (burst == 1) a = ((a / nb) * nb + nb) % 64'h1_0000_0000;
            else if (burst == 2) begin
                bnd = longint'(len + 1) * nb;
                a = (a / bnd) * bnd + (a + nb) % bnd;
            end
        end
        resp = (bad || wl) ? 2 : (dec ? 3 : 0);
    endtask

    task automatic run_burst(input string tag, input logic [IW-1:0] id, input logic [31:0] addr,
                             input int len, input int size, input int burst, input int wl_beat,
                             input int bdelay, input bit gaps, input bit full_strb);
        int exp_resp;
        int t;
        for (int b = 0; b <= len; b++) begin
            data_a[b] = {$urandom, $urandom, $urandom, $urandom};
            strb_a[b] = full_strb ? '1 : NB'($urandom);
        end
        model(addr, len, size, burst, wl_beat, exp_resp);
        got_addr.delete(); got_data.delete(); got_be.delete(); got_cyc.delete();
        @(negedge ACLK);
        BREADY  = (bdelay == 0);
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = 8'(len);
        AWSIZE  = 3'(size);
        AWBURST = 2'(burst);
        AWVALID = 1'b1;
        t = 0;
        while (AWREADY !== 1'b1 && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) check({tag, "_aw_timeout"}, 1, 0);
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                WVALID = 1'b0;
                @(negedge ACLK);
            end
            WVALID = 1'b1;
            WDATA  = data_a[b];
            WSTRB  = strb_a[b];
            WLAST  = (b == wl_beat);
            t = 0;
            while (WREADY !== 1'b1 && t < 50) begin @(negedge ACLK); t++; end
            if (t >= 50) begin check({tag, "_w_timeout"}, 1, 0); break; end
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check({tag, "_wready_after_last"}, DW'(WREADY), 0);
        check({tag, "_bvalid"}, DW'(BVALID), 1);
        for (int k = 0; k < bdelay; k++) begin
            check({tag, "_hold_bvalid"}, DW'(BVALID), 1);
            check({tag, "_hold_bid"}, DW'(BID), DW'(id));
            check({tag, "_hold_bresp"}, DW'(BRESP), DW'(exp_resp));
            check({tag, "_hold_awready"}, DW'(AWREADY), 0);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        check({tag, "_bid"}, DW'(BID), DW'(id));
        check({tag, "_bresp"}, DW'(BRESP), DW'(exp_resp));
        @(negedge ACLK);
        check({tag, "_bvalid_clear"}, DW'(BVALID), 0);
        check({tag, "_awready_back"}, DW'(AWREADY), 1);
        check({tag, "_nwrites"}, DW'(got_addr.size()), DW'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), DW'(got_addr[i]), DW'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_be%0d", tag, i), DW'(got_be[i]), DW'(exp_be[i]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, size, burst, wl;
        logic [31:0] addr;

        // reset state
        repeat (2) @(negedge ACLK);
        check("rst_awready", DW'(AWREADY), 0);
        check("rst_wready", DW'(WREADY), 0);
        check("rst_bvalid", DW'(BVALID), 0);
        check("rst_mem_we", DW'(mem_we), 0);
        check("rst_bid_bresp", DW'({BID, BRESP}), 0);
        check("rst_mem_addr", DW'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be", DW'(mem_be), 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_awready_after_release", DW'(AWREADY), 1);

        // W before AW stalls
        WVALID = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            check("idle_wready_low", DW'(WREADY), 0);
            check("idle_no_write", DW'(mem_we), 0);
        end
        WVALID = 1'b0;

        run_burst("incr", 8'h5a, 32'h100, 3, 4, 1, 3, 0, 0, 1);
        check("incr_a0", DW'(got_addr[0]), 'h100);
        check("incr_a3", DW'(got_addr[3]), 'h130);
        check("incr_consecutive", DW'(got_cyc[3] - got_cyc[0]), 3);

        run_burst("wrap", 8'h11, 32'h38, 3, 3, 2, 3, 0, 0, 1);
        check("wrap_a1", DW'(got_addr[1]), 'h20);

        run_burst("narrow", 8'h22, 32'h3, 2, 0, 1, 2, 0, 0, 1);
        check("narrow_be0", DW'(got_be[0]), 'h08);
        check("narrow_be1", DW'(got_be[1]), 'h10);
        check("narrow_be2", DW'(got_be[2]), 'h20);

        run_burst("wlast_early", 8'h33, 32'h400, 3, 4, 1, 1, 0, 0, 1);
        run_burst("wrap_len2", 8'h44, 32'h40, 2, 4, 2, 2, 0, 0, 1);
        run_burst("decerr", 8'h55, MEMB - 16, 1, 4, 1, 1, 0, 0, 1);
        run_burst("bstall", 8'h66, 32'h800, 1, 4, 1, 1, 10, 0, 1);

        // reset mid-burst
        @(negedge ACLK);
        AWID = 8'h77; AWADDR = 32'h200; AWLEN = 8'd3; AWSIZE = 3'd4; AWBURST = 2'd1;
        AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            WVALID = 1'b1; WDATA = {4{$urandom}}; WSTRB = '1; WLAST = 1'b0;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        ARESETn = 1'b0;
        #1;
        check("midrst_awready", DW'(AWREADY), 0);
        check("midrst_wready", DW'(WREADY), 0);
        check("midrst_bvalid", DW'(BVALID), 0);
        check("midrst_mem_we", DW'(mem_we), 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("midrst_awready_release", DW'(AWREADY), 1);
        repeat (10) begin
            @(negedge ACLK);
            check("midrst_no_bvalid", DW'(BVALID), 0);
        end
        run_burst("post_rst", 8'h78, 32'h300, 1, 4, 1, 1, 0, 0, 1);

        // randomized bursts
        for (int n = 0; n < 25; n++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            size  = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 4);
            if (burst == 2 && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else len = $urandom_range(0, 7);
            addr = ($urandom_range(0, 3) == 0) ? 32'(MEMB - 64 + $urandom_range(0, 63))
                                               : 32'($urandom_range(0, 4095));
            if (burst == 2 && $urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << size) - 32'd1);
            wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
            run_burst($sformatf("rnd%0d", n), IW'($urandom), addr, len, size, burst, wl,
                      $urandom_range(0, 2), 1, $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/asi_w_mem.md
Name: asi_w_mem

Overview:
AXI4 slave write-path responder: the target-side counterpart of the team's AXI master write interface. It accepts one AW burst at a time, accepts the W beats, generates per-beat addresses for FIXED, INCR and WRAP bursts, and drives a single-port byte-enabled memory write port. It then returns one B response. It sits between the AXI interconnect and an on-chip SRAM or register bank.

Parameters:
AXI_DW, 128, data bus width (power of 2, >= 8)
AXI_AW, 32, address width (<= 32)
AXI_IW, 8, ID width
AXI_LW, 8, AWLEN width
AXI_SW, 3, AWSIZE width
AXI_BURSTW, 2, AWBURST width
AXI_BRESPW, 2, BRESP width
MEM_BYTES, 65536, decoded memory size in bytes; addresses >= MEM_BYTES are out of range
AXI_BYTES, AXI_DW/8, derived: bytes per beat
AXI_WSTRBW, AXI_BYTES, derived: WSTRB width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWID  in  AXI_IW  write ID
AWADDR  in  AXI_AW  burst start byte address
AWLEN  in  AXI_LW  beats-1
AWSIZE  in  AXI_SW  log2 bytes per beat
AWBURST  in  AXI_BURSTW  0=FIXED 1=INCR 2=WRAP
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  AXI_DW  write data
WSTRB  in  AXI_WSTRBW  byte strobes
WLAST  in  1  last beat marker
WVALID  in  1  data valid
WREADY  out  1  data ready
BID  out  AXI_IW  response ID
BRESP  out  AXI_BRESPW  0=OKAY 2=SLVERR 3=DECERR
BVALID  out  1  response valid
BREADY  in  1  response ready
mem_we  out  1  memory write strobe
mem_addr  out  AXI_AW  byte address, aligned down to AXI_BYTES
mem_wdata  out  AXI_DW  write data
mem_be  out  AXI_WSTRBW  byte enables

Behaviour:
- Reset: one clock ACLK; ARESETn asynchronous, active-low. Asserting ARESETn forces state IDLE; AWREADY, WREADY, BVALID and mem_we go to 0; BID, BRESP, mem_addr, mem_wdata and mem_be go to 0. Reset mid-burst abandons the burst, with no B response afterwards.
- FSM states: IDLE, DATA, RESP. AWREADY, WREADY and BVALID are registered.
- IDLE: AWREADY=1 from the first cycle after reset release.
  - AW handshake at cycle t latches ID, ADDR, LEN, SIZE and BURST, clears the beat counter and the error flags.
  - At t+1: AWREADY=0, WREADY=1, state DATA.
- DATA: each W handshake (WVALID&WREADY) at cycle t:
  - At t+1: mem_we=1 with that beat's aligned address and WDATA.
  - mem_be = WSTRB & lane mask. Lane mask = bytes [addr%AXI_BYTES, addr%AXI_BYTES + 2^SIZE) of the beat's address, aligned down to 2^SIZE after the first beat.
  - mem_we=0 in every cycle without a preceding handshake.
- Burst end is counted, not taken from WLAST: the beat with counter == LEN is last.
  - WLAST=1 on any earlier beat, or WLAST=0 on the counted last beat, sets SLVERR.
  - Last-beat handshake at t: WREADY=0 and BVALID=1 at t+1, state RESP.
- Address update per beat:
  - FIXED: address held.
  - INCR: next = (addr aligned down to 2^SIZE) + 2^SIZE, modulo 2^AXI_AW.
  - WRAP: wrap boundary = (LEN+1)*2^SIZE. next = lower bound + ((addr + 2^SIZE) mod boundary), where lower bound = addr aligned down to boundary.
- Errors:
  - SLVERR: SIZE > log2(AXI_BYTES); WRAP with LEN not in {1,3,7,15}; WRAP with unaligned start; BURST=3; WLAST mismatch.
  - SLVERR from a SIZE, WRAP, BURST or AW-phase cause suppresses mem_we for the whole burst. A WLAST mismatch is not known until the offending beat and does not retro-suppress beats already written; it only sets BRESP.
  - DECERR: any beat address >= MEM_BYTES. That beat is not written; the other beats are written.
  - Precedence: SLVERR > DECERR > OKAY.
- RESP: BVALID held with BID and BRESP stable until BREADY. Handshake at t: BVALID=0, AWREADY=1 at t+1, state IDLE.
- One outstanding burst: AWVALID during DATA/RESP waits. W beats arriving before AW are left stalled (WREADY=0 in IDLE).
- Peak throughput: one beat per cycle. Per-burst overhead: one idle cycle for AW, one for B.

Test Plan:
- INCR, AWADDR=0x100, LEN=3, SIZE=4, WSTRB all-ones, BREADY=1 -> mem_we pulses at 0x100, 0x110, 0x120, 0x130 on consecutive cycles; BRESP=0; BID equals AWID.
- WRAP, AWADDR=0x38, LEN=3, SIZE=3, AXI_DW=64 -> addresses 0x38, 0x20, 0x28, 0x30 (wrap boundary 32 bytes); mem_be 0xFF; OKAY.
- Narrow INCR, AWADDR=0x3, SIZE=0, LEN=2, WSTRB=0xFF, AXI_DW=64 -> mem_addr 0x0 for all three beats; mem_be 0x08, 0x10, 0x20.
- WLAST on beat 1 of LEN=3 -> all 4 beats accepted (beat 0 written before the mismatch is detected), BRESP=2.
- WRAP with LEN=2 -> no mem_we for the burst, BRESP=2.
- AWADDR=MEM_BYTES-16, SIZE=4, LEN=1 -> beat 0 written, beat 1 suppressed, BRESP=3.
- BREADY held low for 10 cycles -> BVALID, BID and BRESP stable throughout, AWREADY=0; AWREADY=1 one cycle after the handshake.
- ARESETn pulsed low after beat 1 of 4 -> AWREADY, WREADY, BVALID and mem_we all 0 immediately; after release, AWREADY=1 and no B response is issued.
